dibit_byte_rx: RTL and testbench

- Receive-side counterpart of the transmit bit-order stage.
- Accepts the 2-bit-per-clock RMII-style dibit stream as it arrives from the wire, with the least-significant dibit of each byte first. Reassembles each byte, flags the last byte of every frame, reports the frame length and detects frames that end on a partial byte.
- Sits between the PHY-facing dibit sampler and the byte-wide frame parser.

---
 rtl/dibit_byte_rx.sv | 139 +++++++++++++
 tb/tb_dibit_byte_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dibit_byte_rx.sv
`default_nettype none
// ============================================================================
// Module      : dibit_byte_rx
// Description : Receive-side dibit-to-byte reassembly for an RMII-style
//               2-bit-per-clock stream. Rebuilds each byte, marks the
//               last byte of a frame, reports the frame length, and flags
//               frames that end on a partial byte.
// Revision    : 1.0 - initial release
// ============================================================================
module dibit_byte_rx #(
  parameter int LSB_FIRST = 1,
  parameter int LEN_W     = 11
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             axiiv,
  input  logic [1:0]       axiid,
  output logic             axiov,
  output logic [7:0]       axiod,
  output logic             axiol,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_err
);

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  // Assembly state
  logic [1:0]       cnt_q,  cnt_d;
  logic [7:0]       sr_q,   sr_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [LEN_W-1:0] len_q,  len_d;
  logic             vld_q,  vld_d;     // axiiv seen on the previous edge

  // Output registers
  logic             axiov_q,     axiov_d;
  logic [7:0]       axiod_q,     axiod_d;
  logic             axiol_q,     axiol_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             frame_err_q, frame_err_d;

  // Shift register contents after accepting the current dibit
  logic [7:0]       sr_shift;

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      // First dibit ends up in [1:0] after four shifts right
      assign sr_shift = {axiid, sr_q[7:2]};
    end else begin : g_msb_first
      // First dibit ends up in [7:6] after four shifts left
      assign sr_shift = {sr_q[5:0], axiid};
    end
  endgenerate

  // Next-state: dibit assembly, byte hand-off, frame termination
  always_comb begin
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    hold_v_d    = 1'b0;          // a held byte is always emitted on the next edge
    len_d       = len_q;
    vld_d       = axiiv;
    axiov_d     = hold_v_q;
    axiod_d     = axiod_q;
    axiol_d     = 1'b0;
    frame_len_d = frame_len_q;
    frame_err_d = 1'b0;

    // Emission of the byte completed on the previous edge
    if (hold_v_q) begin
      axiod_d = hold_q;
      if (!axiiv) begin
        // Envelope dropped right after a whole byte: this is the last one
        axiol_d     = 1'b1;
        frame_len_d = len_q;
        len_d       = '0;
      end
    end

    if (axiiv) begin
      sr_d  = sr_shift;
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        hold_d   = sr_shift;
        hold_v_d = 1'b1;
        if (len_q != LEN_MAX) begin
          len_d = len_q + LEN_ONE;
        end
      end
    end else begin
      // Any idle edge leaves the assembler empty
      sr_d  = '0;
      cnt_d = 2'd0;
      if (vld_q && (cnt_q != 2'd0)) begin
        // Frame ended mid-byte: discard the stray dibits
        frame_err_d = 1'b1;
        len_d       = '0;
      end
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= 2'd0;
      sr_q        <= 8'h00;
      hold_q      <= 8'h00;
      hold_v_q    <= 1'b0;
      len_q       <= '0;
      vld_q       <= 1'b0;
      axiov_q     <= 1'b0;
      axiod_q     <= 8'h00;
      axiol_q     <= 1'b0;
      frame_len_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      len_q       <= len_d;
      vld_q       <= vld_d;
      axiov_q     <= axiov_d;
      axiod_q     <= axiod_d;
      axiol_q     <= axiol_d;
      frame_len_q <= frame_len_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign axiov     = axiov_q;
  assign axiod     = axiod_q;
  assign axiol     = axiol_q;
  assign frame_len = frame_len_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dibit_byte_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_dibit_byte_rx
// Description : Scoreboard bench for dibit_byte_rx. Two instances share the
//               input stream: LSB-first with an 11-bit length, and
//               MSB-first with a 2-bit (quickly saturating) length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dibit_byte_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       axiiv = 1'b0;
  logic [1:0] axiid = 2'b00;

  logic        ov_a, ol_a, fe_a;
  logic [7:0]  od_a;
  logic [10:0] fl_a;
  logic        ov_b, ol_b, fe_b;
  logic [7:0]  od_b;
  logic [1:0]  fl_b;

  always #5 clk = ~clk;

  dibit_byte_rx #(.LSB_FIRST(1), .LEN_W(11)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .axiov(ov_a), .axiod(od_a), .axiol(ol_a), .frame_len(fl_a), .frame_err(fe_a)
  );

  dibit_byte_rx #(.LSB_FIRST(0), .LEN_W(2)) dut_msb (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .axiov(ov_b), .axiod(od_b), .axiol(ol_b), .frame_len(fl_b), .frame_err(fe_b)
  );

  typedef struct {
    logic [7:0] d_lsb;
    logic [7:0] d_msb;
    bit         last;
    int         len_a;
    int         len_b;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops expectations whenever either DUT presents a pulse
  exp_t m_e;
  int   m_c;
  always @(negedge clk) begin
    if (rst) begin
      if (ov_a || ov_b) begin
        if (exp_q.size() == 0) begin
          check("unexpected_axiov", 32'(ov_a | ov_b), 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          check("axiov_lsb", 32'(ov_a), 32'd1);
          check("axiov_msb", 32'(ov_b), 32'd1);
          check("axiov_cycle", cyc, m_e.cyc);
          check("axiod_lsb", 32'(od_a), 32'(m_e.d_lsb));
          check("axiod_msb", 32'(od_b), 32'(m_e.d_msb));
          check("axiol_lsb", 32'(ol_a), 32'(m_e.last));
          check("axiol_msb", 32'(ol_b), 32'(m_e.last));
          check("err_with_axiov", 32'(fe_a | fe_b), 32'd0);
          if (m_e.last) begin
            check("frame_len_lsb", 32'(fl_a), m_e.len_a);
            check("frame_len_msb", 32'(fl_b), m_e.len_b);
          end
        end
      end
      if (fe_a || fe_b) begin
        if (err_q.size() == 0) begin
          check("unexpected_frame_err", 32'(fe_a | fe_b), 32'd0);
        end else begin
          m_c = err_q.pop_front();
          check("frame_err_lsb", 32'(fe_a), 32'd1);
          check("frame_err_msb", 32'(fe_b), 32'd1);
          check("frame_err_cycle", cyc, m_c);
        end
      end
    end
  end

  // Drive one cycle of input, then move to just after the next rising edge
  task automatic put(input logic v, input logic [1:0] d);
    axiiv = v;
    axiid = d;
    @(posedge clk);
    #1;
  endtask

  // Send byte b (LSB dibit first on the wire); msb is the value the
  // MSB-first instance assembles from the same dibits
  task automatic send_byte(input logic [7:0] b, input logic [7:0] msb,
                           input bit last, input int la, input int lb);
    exp_t e;
    put(1'b1, b[1:0]);
    put(1'b1, b[3:2]);
    put(1'b1, b[5:4]);
    e.d_lsb = b;
    e.d_msb = msb;
    e.last  = last;
    e.len_a = la;
    e.len_b = lb;
    e.cyc   = cyc + 2;   // sampled next edge, emitted the edge after
    exp_q.push_back(e);
    put(1'b1, b[7:6]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_axiov_lsb"}, 32'(ov_a), 32'd0);
    check({tag, "_axiod_lsb"}, 32'(od_a), 32'd0);
    check({tag, "_axiol_lsb"}, 32'(ol_a), 32'd0);
    check({tag, "_len_lsb"},   32'(fl_a), 32'd0);
    check({tag, "_err_lsb"},   32'(fe_a), 32'd0);
    check({tag, "_axiov_msb"}, 32'(ov_b), 32'd0);
    check({tag, "_axiod_msb"}, 32'(od_b), 32'd0);
    check({tag, "_axiol_msb"}, 32'(ol_b), 32'd0);
    check({tag, "_len_msb"},   32'(fl_b), 32'd0);
    check({tag, "_err_msb"},   32'(fe_b), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    put(1'b0, 2'b00);

    // Basic byte: dibits 01,01,10,10
    send_byte(8'hA5, 8'h5A, 1'b1, 1, 1);
    put(1'b0, 2'b00);

    // Multi-byte frame, continuous
    send_byte(8'h55, 8'h55, 1'b0, 0, 0);
    send_byte(8'hD5, 8'h57, 1'b0, 0, 0);
    send_byte(8'h3C, 8'h3C, 1'b1, 3, 3);
    put(1'b0, 2'b00);

    // Trailing partial byte: two stray dibits
    send_byte(8'hFF, 8'hFF, 1'b0, 0, 0);
    put(1'b1, 2'b11);
    put(1'b1, 2'b10);
    err_q.push_back(cyc + 1);
    put(1'b0, 2'b00);

    // Order: dibits 10,10,01,01
    send_byte(8'h5A, 8'hA5, 1'b1, 1, 1);
    put(1'b0, 2'b00);

    // Back-to-back single-byte frames with one idle cycle between
    send_byte(8'h12, 8'h84, 1'b1, 1, 1);
    put(1'b0, 2'b00);
    send_byte(8'h34, 8'h1C, 1'b1, 1, 1);
    put(1'b0, 2'b00);

    // Third frame cut by reset after two dibits
    put(1'b1, 2'b01);
    put(1'b1, 2'b10);
    rst = 1'b0;
    #1 check_outputs_zero("midreset");
    axiiv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    put(1'b0, 2'b00);

    // Clean frame after reset
    send_byte(8'hC3, 8'hC3, 1'b1, 1, 1);
    put(1'b0, 2'b00);

    // Five-byte frame: 2-bit length saturates at 3
    send_byte(8'h01, 8'h40, 1'b0, 0, 0);
    send_byte(8'h02, 8'h80, 1'b0, 0, 0);
    send_byte(8'h03, 8'hC0, 1'b0, 0, 0);
    send_byte(8'h04, 8'h10, 1'b0, 0, 0);
    send_byte(8'h05, 8'h50, 1'b1, 5, 3);
    put(1'b0, 2'b00);

    // Idle: no further pulses allowed
    repeat (10) put(1'b0, 2'b00);

    check("bytes_outstanding", exp_q.size(), 32'd0);
    check("errs_outstanding",  err_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
